// File: rtl/tetris_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : tetris_pkg                                                        |
// | Brief   : Piece encoding, bag constants and dispenser state encoding.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package tetris_pkg;

    typedef enum logic [2:0] {
        I = 3'd0,
        O = 3'd1,
        J = 3'd2,
        L = 3'd3,
        S = 3'd4,
        T = 3'd5,
        Z = 3'd6
    } piece_e;

    localparam int         c_num_pieces = 7;
    localparam logic [6:0] c_full_bag   = 7'h7F;

    typedef enum logic [0:0] {
        eFill = 1'b0,
        eFull = 1'b1
    } state_e;

    // Fallback choice when the random draw keeps missing the bag.
    function automatic piece_e lowest_piece(input logic [6:0] bag);
        piece_e pick;
        pick = I;
        for (int k = c_num_pieces - 1; k >= 0; k--) begin
            if (bag[k]) pick = piece_e'(k[2:0]);
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piece_dispenser_if.sv
// +----------------------------------------------------------------------------+
// | Module  : piece_dispenser_if                                                |
// | Brief   : Random input, head-piece handshake and preview bus.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface piece_dispenser_if #(
    parameter int rand_width_p    = 65,
    parameter int preview_depth_p = 3
);
    logic [rand_width_p-1:0]      random_i;
    logic                         piece_v_o;
    logic [2:0]                   piece_o;
    logic                         piece_ready_i;
    logic [3*preview_depth_p-1:0] preview_o;
    logic [preview_depth_p-1:0]   preview_v_o;

    modport master (
        input  random_i, piece_ready_i,
        output piece_v_o, piece_o, preview_o, preview_v_o
    );

    modport slave (
        output random_i, piece_ready_i,
        input  piece_v_o, piece_o, preview_o, preview_v_o
    );
endinterface

`default_nettype wire

// File: rtl/piece_dispenser_fifo.sv
// +----------------------------------------------------------------------------+
// | Module  : piece_fifo                                                        |
// | Brief   : Shift queue of pieces with parallel read; entry 0 is the head.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module piece_fifo #(
    parameter int depth_p = 4,
    localparam int c_cnt_w = $clog2(depth_p + 1)
) (
    input  wire logic                   clk_i,
    input  wire logic                   reset_n_i,
    input  wire logic                   push_i,
    input  wire logic [2:0]             push_data_i,
    input  wire logic                   pop_i,
    output logic      [3*depth_p-1:0]   entries_o,
    output logic      [c_cnt_w-1:0]     count_o,
    output logic                        empty_o
);
    logic [2:0]         r_mem     [depth_p];
    logic [2:0]         w_mem_nxt [depth_p];
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_wr_idx;

    // Vacated tail slots are zero-filled so invalid entries always read 0.
    always_comb begin
        w_wr_idx = pop_i ? r_count - c_cnt_w'(1) : r_count;
        for (int k = 0; k < depth_p - 1; k++) begin
            w_mem_nxt[k] = pop_i ? r_mem[k+1] : r_mem[k];
        end
        w_mem_nxt[depth_p-1] = pop_i ? 3'd0 : r_mem[depth_p-1];
        for (int k = 0; k < depth_p; k++) begin
            if (push_i && (w_wr_idx == k[c_cnt_w-1:0])) w_mem_nxt[k] = push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < depth_p; k++) r_mem[k] <= 3'd0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < depth_p; k++) r_mem[k] <= w_mem_nxt[k];
            r_count <= r_count + c_cnt_w'(push_i) - c_cnt_w'(pop_i);
        end
    end

    generate
        for (genvar k = 0; k < depth_p; k++) begin : g_pack
            assign entries_o[3*k +: 3] = r_mem[k];
        end
    endgenerate

    assign count_o = r_count;
    assign empty_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/piece_dispenser.sv
// +----------------------------------------------------------------------------+
// | Module  : piece_dispenser                                                   |
// | Brief   : 7-bag tetromino dispenser with preview queue and forced picks.    |
// |           PIECE_DISPENSER_STATS_EN adds a saturating reject_count_o port.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module piece_dispenser
    import tetris_pkg::*;
#(
    parameter int rand_width_p    = 65,
    parameter int preview_depth_p = 3,
    parameter int max_reject_p    = 4
) (
    input  wire logic          clk_i,
    input  wire logic          reset_n_i,
    piece_dispenser_if.master  bus
`ifdef PIECE_DISPENSER_STATS_EN
    ,
    output logic [15:0]        reject_count_o
`endif
);
    localparam int c_depth = preview_depth_p + 1;
    localparam int c_cnt_w = $clog2(c_depth + 1);
    localparam int c_rej_w = (max_reject_p > 1) ? $clog2(max_reject_p) : 1;

    state_e               r_state, w_state_nxt;
    logic [6:0]           r_bag, w_bag_clr;
    logic [c_rej_w-1:0]   r_reject_cnt;
    logic [2:0]           w_cand, w_pick;
    logic                 w_accept, w_forced, w_draw, w_push, w_pop;
    logic [3*c_depth-1:0] w_entries;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_empty;

    assign w_cand   = bus.random_i[2:0];
    assign w_accept = (w_cand != 3'd7) && r_bag[w_cand];
    assign w_forced = !w_accept && (r_reject_cnt == c_rej_w'(max_reject_p - 1));
    assign w_pop    = bus.piece_v_o && bus.piece_ready_i;
    assign w_push   = w_draw && (w_accept || w_forced);

    always_comb begin
        w_pick = lowest_piece(r_bag);
        if (w_accept) w_pick = w_cand;
    end

    assign w_bag_clr = r_bag & ~(7'd1 << w_pick);

    // A pop frees a slot, so even a full queue draws on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_draw      = (r_state == eFill) || w_pop;
        case (r_state)
            eFill:   if (w_push && !w_pop && (w_count == c_cnt_w'(preview_depth_p)))
                         w_state_nxt = eFull;
            eFull:   if (w_pop && !w_push) w_state_nxt = eFill;
            default: w_state_nxt = eFill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= eFill;
            r_bag        <= c_full_bag;
            r_reject_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_bag <= (w_bag_clr == 7'd0) ? c_full_bag : w_bag_clr;
            if (w_draw) r_reject_cnt <= w_push ? '0 : r_reject_cnt + c_rej_w'(1);
        end
    end

    piece_fifo #(
        .depth_p (c_depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (w_push),
        .push_data_i (w_pick),
        .pop_i       (w_pop),
        .entries_o   (w_entries),
        .count_o     (w_count),
        .empty_o     (w_empty)
    );

    assign bus.piece_v_o = !w_empty;
    assign bus.piece_o   = w_entries[2:0];
    assign bus.preview_o = w_entries[3*c_depth-1:3];

    generate
        for (genvar k = 0; k < preview_depth_p; k++) begin : g_preview_v
            assign bus.preview_v_o[k] = (w_count > c_cnt_w'(k + 1));
        end
        if (rand_width_p > 3) begin : g_rand_unused
            logic w_unused_rand;
            assign w_unused_rand = ^bus.random_i[rand_width_p-1:3];
        end
    endgenerate

`ifdef PIECE_DISPENSER_STATS_EN
    logic [15:0] r_reject_count;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_reject_count <= 16'd0;
        end else if (w_draw && !w_accept && (r_reject_count != 16'hFFFF)) begin
            r_reject_count <= r_reject_count + 16'd1;
        end
    end

    assign reject_count_o = r_reject_count;
`endif

endmodule

`default_nettype wire
